// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: start-up sequencer for the rv32i_sc core.
// Streams a data image into the data BRAM write port, then a program image
// into the instruction BRAM write port, then releases the core from stall.
module boot_loader_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 9,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  d_count,
  input  logic [CNT_WIDTH-1:0]  i_count,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic                  d_bram_init_done,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  pc_stall,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_LOAD_I,
    S_DRAIN,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  r_dCount;
  logic [CNT_WIDTH-1:0]  r_iCount;
  logic                  r_dWEnb;
  logic [ADDR_WIDTH-1:0] r_dWAddr;
  logic [DATA_WIDTH-1:0] r_dWDat;
  logic                  r_iWEnb;
  logic [ADDR_WIDTH-1:0] r_iWAddr;
  logic [DATA_WIDTH-1:0] r_iWDat;

  logic                  w_accept;
  logic                  w_startOk;
  logic                  w_overflow;
  logic                  w_lastD;
  logic                  w_lastI;
  logic [ADDR_WIDTH-1:0] w_byteAddr;

  // src_ready depends only on state, so w_accept has no valid-to-ready loop.
  assign w_accept   = src_valid && src_ready;
  assign w_startOk  = (r_state == S_IDLE) && start;
  assign w_overflow = (d_count > MAX_CNT) || (i_count > MAX_CNT);
  assign w_lastD    = (r_idx == (r_dCount - ONE_CNT));
  assign w_lastI    = (r_idx == (r_iCount - ONE_CNT));
  assign w_byteAddr = ADDR_WIDTH'({r_idx, 2'b00});

  // State register; reset aborts any load in progress immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: start only counts in IDLE, RUN and ERROR are sticky.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_overflow)          w_nextState = S_ERROR;
          else if (d_count != '0)  w_nextState = S_LOAD_D;
          else if (i_count != '0)  w_nextState = S_LOAD_I;
          else                     w_nextState = S_DRAIN;
        end
      end
      S_LOAD_D: begin
        if (w_accept && w_lastD) begin
          w_nextState = (r_iCount != '0) ? S_LOAD_I : S_DRAIN;
        end
      end
      S_LOAD_I: begin
        if (w_accept && w_lastI) w_nextState = S_DRAIN;
      end
      S_DRAIN:   w_nextState = S_RELEASE;
      S_RELEASE: w_nextState = S_RUN;
      S_RUN:     w_nextState = S_RUN;
      S_ERROR:   w_nextState = S_ERROR;
      default:   w_nextState = S_IDLE;
    endcase
  end

  // Moore outputs: handshake, core control and status decoded from state.
  always_comb begin
    src_ready        = 1'b0;
    busy             = 1'b0;
    d_bram_init_done = 1'b0;
    i_r_enb          = 1'b0;
    rd_enbl          = 1'b0;
    pc_stall         = 1'b1;
    done             = 1'b0;
    err              = 1'b0;
    case (r_state)
      S_LOAD_D, S_LOAD_I: begin
        src_ready = 1'b1;
        busy      = 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_RELEASE: begin
        busy             = 1'b1;
        d_bram_init_done = 1'b1;
        i_r_enb          = 1'b1;
        rd_enbl          = 1'b1;
      end
      S_RUN: begin
        d_bram_init_done = 1'b1;
        i_r_enb          = 1'b1;
        rd_enbl          = 1'b1;
        pc_stall         = 1'b0;
        done             = 1'b1;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        pc_stall = 1'b1;
      end
    endcase
  end

  // Word index and latched counts; index restarts at 0 for each image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx    <= '0;
      r_dCount <= '0;
      r_iCount <= '0;
    end else if (w_startOk) begin
      r_idx    <= '0;
      r_dCount <= d_count;
      r_iCount <= i_count;
    end else if (w_accept) begin
      if (((r_state == S_LOAD_D) && w_lastD) || ((r_state == S_LOAD_I) && w_lastI)) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + ONE_CNT;
      end
    end
  end

  // Registered BRAM write ports: one-cycle enable pulse per accepted word,
  // address and data hold their last value between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dWEnb  <= 1'b0;
      r_dWAddr <= '0;
      r_dWDat  <= '0;
      r_iWEnb  <= 1'b0;
      r_iWAddr <= '0;
      r_iWDat  <= '0;
    end else begin
      r_dWEnb <= 1'b0;
      r_iWEnb <= 1'b0;
      if (w_accept && (r_state == S_LOAD_D)) begin
        r_dWEnb  <= 1'b1;
        r_dWAddr <= w_byteAddr;
        r_dWDat  <= src_data;
      end
      if (w_accept && (r_state == S_LOAD_I)) begin
        r_iWEnb  <= 1'b1;
        r_iWAddr <= w_byteAddr;
        r_iWDat  <= src_data;
      end
    end
  end

  assign d_w_enb  = r_dWEnb;
  assign d_w_addr = r_dWAddr;
  assign d_w_dat  = r_dWDat;
  assign i_w_enb  = r_iWEnb;
  assign i_w_addr = r_iWAddr;
  assign i_w_dat  = r_iWDat;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: scoreboard bench for boot_loader_ctrl.
// The source driver pushes each accepted word's expected write into a queue;
// a monitor pops and compares whenever a BRAM write enable is seen.
module tb_boot_loader_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] d_count = '0;
  logic [CW-1:0] i_count = '0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic [AW-1:0] d_w_addr;
  logic [DW-1:0] d_w_dat;
  logic          d_w_enb;
  logic [AW-1:0] i_w_addr;
  logic [DW-1:0] i_w_dat;
  logic          i_w_enb;
  logic          d_bram_init_done;
  logic          i_r_enb;
  logic          rd_enbl;
  logic          pc_stall;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t dExpQ[$];
  wr_t iExpQ[$];
  int  nVec = 0;
  int  nMis = 0;
  int  dWr = 0;
  int  iWr = 0;

  boot_loader_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_WORDS(256)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .d_count(d_count), .i_count(i_count),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_bram_init_done(d_bram_init_done), .i_r_enb(i_r_enb), .rd_enbl(rd_enbl),
    .pc_stall(pc_stall), .busy(busy), .done(done), .err(err)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Distinct, recognisable word per image, index and test.
  function automatic logic [31:0] wordOf(input bit isD, input int k, input logic [7:0] salt);
    logic [15:0] kLow;
    kLow = k[15:0];
    return {(isD ? 8'hDA : 8'h1C), salt, kLow};
  endfunction

  // Monitor: every write pulse must match the oldest expected write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (d_w_enb === 1'b1) begin
        dWr++;
        if (dExpQ.size() == 0) begin
          checkOutput("d_unexpected_write", {31'b0, d_w_enb}, 32'd0);
        end else begin
          e = dExpQ.pop_front();
          checkOutput("d_w_addr", {22'b0, d_w_addr}, {22'b0, e.addr});
          checkOutput("d_w_dat", d_w_dat, e.dat);
        end
      end
      if (i_w_enb === 1'b1) begin
        iWr++;
        if (iExpQ.size() == 0) begin
          checkOutput("i_unexpected_write", {31'b0, i_w_enb}, 32'd0);
        end else begin
          e = iExpQ.pop_front();
          checkOutput("i_w_addr", {22'b0, i_w_addr}, {22'b0, e.addr});
          checkOutput("i_w_dat", i_w_dat, e.dat);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset values of every output.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_src_ready"}, {31'b0, src_ready}, 32'd0);
    checkOutput({tag, "_d_w_enb"}, {31'b0, d_w_enb}, 32'd0);
    checkOutput({tag, "_i_w_enb"}, {31'b0, i_w_enb}, 32'd0);
    checkOutput({tag, "_d_w_addr"}, {22'b0, d_w_addr}, 32'd0);
    checkOutput({tag, "_i_w_addr"}, {22'b0, i_w_addr}, 32'd0);
    checkOutput({tag, "_d_w_dat"}, d_w_dat, 32'd0);
    checkOutput({tag, "_i_w_dat"}, i_w_dat, 32'd0);
    checkOutput({tag, "_init_done"}, {31'b0, d_bram_init_done}, 32'd0);
    checkOutput({tag, "_i_r_enb"}, {31'b0, i_r_enb}, 32'd0);
    checkOutput({tag, "_rd_enbl"}, {31'b0, rd_enbl}, 32'd0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'b0, err}, 32'd0);
    checkOutput({tag, "_pc_stall"}, {31'b0, pc_stall}, 32'd1);
  endtask

  // Mid-cycle asynchronous reset, checked before any clock edge, then released.
  task automatic applyReset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dExpQ.delete();
    iExpQ.delete();
  endtask

  // Pulse start, then stream words with optional 1-0-1 throttling, an optional
  // spurious start at word spurAt, stopping after stopAfter accepted words.
  task automatic applyStimulus(input int dN, input int iN, input bit throttle,
                               input int spurAt, input int stopAfter,
                               input logic [7:0] salt, output int cycles);
    int  k;
    int  cyc;
    int  total;
    int  limit;
    bit  spurDone;
    wr_t e;
    k = 0;
    cyc = 0;
    spurDone = 1'b0;
    total = dN + iN;
    limit = (stopAfter < total) ? stopAfter : total;
    start = 1'b1;
    d_count = CW'(dN);
    i_count = CW'(iN);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    while (k < limit && cyc < 4 * total + 8) begin
      src_valid = throttle ? ((cyc % 2) == 0) : 1'b1;
      src_data = wordOf(k < dN, (k < dN) ? k : k - dN, salt);
      if (k == spurAt && !spurDone) begin
        start = 1'b1;
        d_count = CW'(1);
        i_count = CW'(1);
        spurDone = 1'b1;
      end
      @(negedge clk);
      if (src_valid && src_ready) begin
        if (k < dN) begin
          e.addr = AW'(k * 4);
          e.dat = src_data;
          dExpQ.push_back(e);
        end else begin
          e.addr = AW'((k - dN) * 4);
          e.dat = src_data;
          iExpQ.push_back(e);
        end
        k++;
      end
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
    end
    src_valid = 1'b0;
    checkOutput("words_accepted", k, limit);
    cycles = cyc;
  endtask

  // DRAIN -> RELEASE -> RUN sequence, entered with the DUT in DRAIN.
  task automatic checkRelease(input string tag);
    checkOutput({tag, "_drain_init_done"}, {31'b0, d_bram_init_done}, 32'd0);
    checkOutput({tag, "_drain_pc_stall"}, {31'b0, pc_stall}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_rel_init_done"}, {31'b0, d_bram_init_done}, 32'd1);
    checkOutput({tag, "_rel_i_r_enb"}, {31'b0, i_r_enb}, 32'd1);
    checkOutput({tag, "_rel_rd_enbl"}, {31'b0, rd_enbl}, 32'd1);
    checkOutput({tag, "_rel_pc_stall"}, {31'b0, pc_stall}, 32'd1);
    checkOutput({tag, "_rel_done"}, {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_run_pc_stall"}, {31'b0, pc_stall}, 32'd0);
    checkOutput({tag, "_run_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_run_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_run_init_done"}, {31'b0, d_bram_init_done}, 32'd1);
  endtask

  // Nothing left in the scoreboard and the right number of write pulses.
  task automatic checkEnd(input string tag, input int dExp, input int iExp, input int d0, input int i0);
    checkOutput({tag, "_d_pending"}, dExpQ.size(), 32'd0);
    checkOutput({tag, "_i_pending"}, iExpQ.size(), 32'd0);
    checkOutput({tag, "_d_writes"}, dWr - d0, dExp);
    checkOutput({tag, "_i_writes"}, iWr - i0, iExp);
  endtask

  initial begin : main
    int cyc;
    int d0;
    int i0;

    #1;
    rst = 1'b0;
    #1;
    checkResetOutputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] nominal load 3+8 with spurious start in LOAD_I and RUN");
    d0 = dWr; i0 = iWr;
    applyStimulus(3, 8, 1'b0, 5, 999, 8'h11, cyc);
    checkOutput("nominal_cycles", cyc, 32'd11);
    checkRelease("nom");
    start = 1'b1;
    d_count = CW'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("run_start_done", {31'b0, done}, 32'd1);
    checkOutput("run_start_pc_stall", {31'b0, pc_stall}, 32'd0);
    checkOutput("run_start_busy", {31'b0, busy}, 32'd0);
    checkEnd("nom", 3, 8, d0, i0);
    applyReset("rst1");

    $display("[TB] throttled source 3+8");
    d0 = dWr; i0 = iWr;
    applyStimulus(3, 8, 1'b1, -1, 999, 8'h22, cyc);
    checkRelease("thr");
    checkEnd("thr", 3, 8, d0, i0);
    applyReset("rst2");

    $display("[TB] zero data count 0+2");
    d0 = dWr; i0 = iWr;
    applyStimulus(0, 2, 1'b0, -1, 999, 8'h33, cyc);
    checkRelease("z02");
    checkEnd("z02", 0, 2, d0, i0);
    applyReset("rst3");

    $display("[TB] zero counts 0+0");
    d0 = dWr; i0 = iWr;
    applyStimulus(0, 0, 1'b0, -1, 999, 8'h44, cyc);
    checkRelease("z00");
    checkEnd("z00", 0, 0, d0, i0);
    applyReset("rst4");

    $display("[TB] maximum image 0+256");
    d0 = dWr; i0 = iWr;
    applyStimulus(0, 256, 1'b0, -1, 999, 8'h55, cyc);
    checkRelease("max");
    checkEnd("max", 0, 256, d0, i0);
    applyReset("rst5");

    $display("[TB] overflow d_count=257");
    d0 = dWr; i0 = iWr;
    start = 1'b1;
    d_count = CW'(257);
    i_count = CW'(1);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ovf_err", {31'b0, err}, 32'd1);
    checkOutput("ovf_busy", {31'b0, busy}, 32'd0);
    checkOutput("ovf_pc_stall", {31'b0, pc_stall}, 32'd1);
    checkOutput("ovf_src_ready", {31'b0, src_ready}, 32'd0);
    src_valid = 1'b1;
    src_data = 32'hBAD0_0001;
    start = 1'b1;
    d_count = CW'(1);
    i_count = CW'(1);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    src_valid = 1'b0;
    checkOutput("ovf_err_sticky", {31'b0, err}, 32'd1);
    checkOutput("ovf_done", {31'b0, done}, 32'd0);
    checkOutput("ovf_pc_stall_sticky", {31'b0, pc_stall}, 32'd1);
    checkEnd("ovf", 0, 0, d0, i0);
    applyReset("rst6");

    $display("[TB] overflow i_count=257");
    start = 1'b1;
    d_count = CW'(2);
    i_count = CW'(257);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ovfi_err", {31'b0, err}, 32'd1);
    applyReset("rst7");

    $display("[TB] reset after 2 of 3 data words, then fresh 1+1 load");
    d0 = dWr; i0 = iWr;
    applyStimulus(3, 2, 1'b0, -1, 2, 8'h77, cyc);
    applyReset("midload");
    checkOutput("midload_d_writes", dWr - d0, 32'd1);
    d0 = dWr; i0 = iWr;
    applyStimulus(1, 1, 1'b0, -1, 999, 8'h88, cyc);
    checkRelease("fresh");
    checkEnd("fresh", 1, 1, d0, i0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- Sequences rv32i_sc start-up: streams a data image into the data BRAM write port, then a program image into the instruction BRAM write port, then releases the core.
- Drives the PC stall, instruction-fetch enable, regfile read enable and `d_bram_init_done` mux select.
- Sits between an external word source (UART/JTAG bridge or bench) and the BRAMs. Replaces ad-hoc loading sequences.

Parameters:
- ADDR_WIDTH, 10, BRAM byte-address width (w_addr ports).
- DATA_WIDTH, 32, word width.
- CNT_WIDTH, 9, width of word-count inputs.
- MAX_WORDS, 256, maximum words per image. Must satisfy MAX_WORDS*4 <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- d_count  in  CNT_WIDTH  data words to load; sampled on accepted start.
- i_count  in  CNT_WIDTH  instruction words to load; sampled on accepted start.
- src_valid  in  1  source word valid.
- src_data  in  DATA_WIDTH  source word.
- src_ready  out  1  loader accepts word.
- d_w_addr  out  ADDR_WIDTH  data BRAM write byte address.
- d_w_dat  out  DATA_WIDTH  data BRAM write data.
- d_w_enb  out  1  data BRAM write enable.
- i_w_addr  out  ADDR_WIDTH  instruction BRAM write byte address.
- i_w_dat  out  DATA_WIDTH  instruction BRAM write data.
- i_w_enb  out  1  instruction BRAM write enable.
- d_bram_init_done  out  1  hands data BRAM port control to the core.
- i_r_enb  out  1  instruction BRAM read enable.
- rd_enbl  out  1  register-file read enable.
- pc_stall  out  1  PC stall.
- busy  out  1  load in progress.
- done  out  1  core running.
- err  out  1  count overflow.

Behaviour:
- Reset (rst=0, async):
  - State is IDLE; word index and latched counts are 0.
  - src_ready, all w_enb, all w_addr/w_dat, d_bram_init_done, i_r_enb, rd_enbl, busy, done, err are 0.
  - pc_stall is 1.
  - Reset mid-load aborts immediately. Partially written BRAM contents are left as is.
- States: IDLE, LOAD_D, LOAD_I, DRAIN, RELEASE, RUN, ERROR.
- From IDLE, on start:
  - If d_count>MAX_WORDS or i_count>MAX_WORDS, go to ERROR.
  - Else go to LOAD_D if d_count!=0, else LOAD_I if i_count!=0, else DRAIN.
  - busy=1 from the next cycle.
- Word acceptance:
  - src_ready=1 only in LOAD_D and LOAD_I.
  - A word is accepted on a rising edge with src_valid&&src_ready. No combinational path from src_valid to src_ready.
- Write timing: all write outputs are registered. The cycle after acceptance of word k (0-based per image):
  - In LOAD_D: d_w_enb=1, d_w_addr=k*4, d_w_dat=word.
  - In LOAD_I: i_w_enb=1, i_w_addr=k*4, i_w_dat=word.
  - w_enb lasts exactly one cycle per word. Address/data hold their last value otherwise.
  - Back-to-back acceptance gives one write per cycle.
- Transitions out of the load states:
  - On acceptance of the last data word, go to LOAD_I (or DRAIN if i_count=0) and reset the index to 0.
  - On acceptance of the last instruction word, go to DRAIN.
  - The final d write may coincide with the first LOAD_I cycle (separate ports; legal).
- DRAIN: one cycle, lets the final write complete. Then go to RELEASE.
- RELEASE: one cycle with d_bram_init_done=1, i_r_enb=1, rd_enbl=1, pc_stall=1. Then go to RUN.
- RUN:
  - pc_stall=0, done=1, busy=0.
  - d_bram_init_done, i_r_enb and rd_enbl stay 1.
  - start is ignored.
  - Only reset leaves RUN.
- ERROR: err=1, busy=0, pc_stall=1, no writes, start ignored. Only reset leaves ERROR.
- start in any state other than IDLE is ignored. src_valid outside the load states is ignored (no consumption).
- Index counter width is CNT_WIDTH. Address is computed as {index,2'b00} truncated to ADDR_WIDTH. No wrap is possible given the MAX_WORDS constraint.

Test Plan:
- Nominal load: start with d_count=3, i_count=8; stream 3 data words then 8 instructions, src_valid held high.
  - Expect d writes at addresses 0x0,0x4,0x8.
  - Expect i writes at addresses 0x0..0x1C, one per cycle.
  - d_bram_init_done rises 2 cycles after the last accept; pc_stall falls 1 cycle later; done=1.
- Throttled source: same counts, src_valid toggled 1-0-1.
  - Writes occur only after accepted words; addresses contiguous; no duplicate or missing writes; 11 write pulses total.
- Zero counts:
  - d_count=0, i_count=2: no d_w_enb; i writes at 0x0,0x4.
  - d_count=0, i_count=0: IDLE→DRAIN→RELEASE→RUN in 3 cycles.
- Overflow: d_count=257 → err=1 the next cycle; no writes; pc_stall stays 1; later start ignored.
- Reset mid-load: assert rst low after 2 of 3 data words accepted.
  - All outputs return to reset values asynchronously; pc_stall=1.
  - After release, a fresh start with d_count=1 writes d_w_addr=0x0.
- Spurious start: pulse start while in LOAD_I and in RUN → no state change, no index reset, write stream unaffected.
